// File: rtl/phy_rx_sync_ctrl.sv
// phy_rx_sync_ctrl
// Receive-side byte alignment for the PHY serial link. Hunts for the COM
// symbol at any bit offset, confirms alignment over a run of consecutive
// aligned COMs, then forwards every non-COM byte with a one-cycle strobe.
// A run of stuck-at-0 / stuck-at-1 bytes drops the link back to hunting.
module phy_rx_sync_ctrl #(
  parameter logic [7:0] COM_SYMBOL = 8'hBC,
  parameter int         COM_NEEDED = 4,   // 1..7
  parameter int         LOSS_LIMIT = 4    // 1..15
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       in_from_rx,
  output logic       active,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic [2:0] com_cnt
);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    SYNCING = 2'd1,
    ACTIVE  = 2'd2
  } state_t;

  localparam logic [2:0] COM_TGT  = 3'(COM_NEEDED);
  localparam logic [3:0] LOSS_TGT = 4'(LOSS_LIMIT);

  state_t      state, state_nxt;
  logic [7:0]  sr;
  logic [2:0]  bit_cnt, bit_cnt_nxt;
  logic [3:0]  loss_cnt, loss_cnt_nxt;
  logic [2:0]  com_cnt_nxt;
  logic        active_nxt;
  logic [7:0]  data_nxt;
  logic        valid_nxt;

  // Window includes the bit being sampled this edge, so a byte is judged on
  // the same edge its last bit arrives (no extra latency).
  logic [7:0]  w;
  logic        boundary;
  logic        is_com;
  logic        is_stuck;
  logic [2:0]  com_inc;
  logic [3:0]  loss_inc;

  assign w        = {sr[6:0], in_from_rx};
  assign boundary = (bit_cnt == 3'd7);
  assign is_com   = (w == COM_SYMBOL);
  assign is_stuck = (w == 8'h00) || (w == 8'hFF);
  assign com_inc  = com_cnt + 3'd1;
  assign loss_inc = loss_cnt + 4'd1;

  // Next-state and next-output decode; everything defaults to hold, except
  // the bit counter which free-runs and the strobe which self-clears.
  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt + 3'd1;
    loss_cnt_nxt = loss_cnt;
    com_cnt_nxt  = com_cnt;
    active_nxt   = active;
    data_nxt     = data_out;
    valid_nxt    = 1'b0;

    case (state)
      HUNT: begin
        // Any bit offset is acceptable; a match re-phases the byte counter
        // so the next boundary lands eight edges later.
        if (is_com) begin
          bit_cnt_nxt = 3'd0;
          com_cnt_nxt = 3'd1;
          if (COM_NEEDED == 1) begin
            state_nxt  = ACTIVE;
            active_nxt = 1'b1;
          end else begin
            state_nxt  = SYNCING;
          end
        end
      end

      SYNCING: begin
        // Only aligned COMs count; a stray pattern off-boundary is ignored.
        if (boundary) begin
          if (is_com) begin
            com_cnt_nxt = com_inc;
            if (com_inc == COM_TGT) begin
              state_nxt  = ACTIVE;
              active_nxt = 1'b1;
            end
          end else begin
            state_nxt   = HUNT;
            com_cnt_nxt = 3'd0;
          end
        end
      end

      ACTIVE: begin
        if (boundary) begin
          if (is_com) begin
            // Idle symbol: swallowed, and it proves the line is not stuck.
            loss_cnt_nxt = 4'd0;
          end else if (is_stuck) begin
            if (loss_inc >= LOSS_TGT) begin
              // Line considered dead: the final stuck byte is not forwarded.
              state_nxt    = HUNT;
              active_nxt   = 1'b0;
              com_cnt_nxt  = 3'd0;
              loss_cnt_nxt = 4'd0;
            end else begin
              loss_cnt_nxt = loss_inc;
              data_nxt     = w;
              valid_nxt    = 1'b1;
            end
          end else begin
            loss_cnt_nxt = 4'd0;
            data_nxt     = w;
            valid_nxt    = 1'b1;
          end
        end
      end

      default: begin
        state_nxt = HUNT;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_32f) begin
    if (reset) state <= HUNT;
    else       state <= state_nxt;
  end

  // Datapath and output registers; reset wins over everything on its edge,
  // including the shift register so re-acquisition starts from a clean window.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      sr        <= 8'h00;
      bit_cnt   <= 3'd0;
      loss_cnt  <= 4'd0;
      com_cnt   <= 3'd0;
      active    <= 1'b0;
      data_out  <= 8'h00;
      valid_out <= 1'b0;
    end else begin
      sr        <= w;
      bit_cnt   <= bit_cnt_nxt;
      loss_cnt  <= loss_cnt_nxt;
      com_cnt   <= com_cnt_nxt;
      active    <= active_nxt;
      data_out  <= data_nxt;
      valid_out <= valid_nxt;
    end
  end

endmodule

// File: doc/phy_rx_sync_ctrl.md
# phy_rx_sync_ctrl

Receive-side synchronization controller for the PHY serial link. It sits on the serial input `in_from_rx` ahead of the serial-to-parallel lane distribution. It hunts for the COM symbol (0xBC, MSB first) at any bit offset, locks byte alignment, and declares the link active after a run of consecutive aligned COMs. While active it forwards each non-COM byte with a one-cycle valid strobe, and it drops back to hunting when the line sticks at all-0 or all-1.

## Interface
Parameters:
- `COM_SYMBOL`, 8'hBC: alignment/idle symbol.
- `COM_NEEDED`, 4: consecutive aligned COMs required to go active; legal range 1..7.
- `LOSS_LIMIT`, 4: consecutive aligned 0x00/0xFF bytes that force loss of sync; legal range 1..15.

Ports:
- `clk_32f`  in  1  bit-rate clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high reset; overrides everything else on the same edge.
- `in_from_rx`  in  1  serial data, MSB first, one bit per `clk_32f`.
- `active`  out  1  link synchronized.
- `data_out`  out  8  last forwarded byte; holds between strobes.
- `valid_out`  out  1  one-cycle strobe for `data_out`.
- `com_cnt`  out  3  aligned COMs counted during sync, saturating at `COM_NEEDED`.

## Operation
- Internal state: shift register `sr[7:0]`, bit counter `bit_cnt[2:0]`, loss counter `loss_cnt[3:0]`, and the FSM.
- Each edge updates `sr <= {sr[6:0], in_from_rx}`.
- Window `w = {sr[6:0], in_from_rx}` is the 8 most recent bits including the current sample.
- Byte boundary is the edge where `bit_cnt == 7`; `bit_cnt` wraps to 0 there.
- FSM states: HUNT, SYNCING, ACTIVE. The reset state is HUNT.
- HUNT:
  - `w` is checked every edge, at any bit offset.
  - On `w == COM_SYMBOL`: `bit_cnt <= 0`, `com_cnt <= 1`.
  - If `COM_NEEDED == 1`, go to ACTIVE; otherwise go to SYNCING.
- SYNCING:
  - Only boundary edges are evaluated; a COM match off the boundary is ignored.
  - Boundary with `w == COM_SYMBOL`: `com_cnt` increments.
  - When the new `com_cnt` equals `COM_NEEDED`: go to ACTIVE and set `active <= 1` on that edge.
  - Boundary with any other byte: go to HUNT, `com_cnt <= 0`.
- ACTIVE, evaluated at boundary edges only:
  - `w == COM_SYMBOL`: idle byte; no strobe; `loss_cnt <= 0`.
  - `w` is 0x00 or 0xFF: `loss_cnt` increments.
    - If the new value is below `LOSS_LIMIT`, forward the byte: `data_out <= w`, `valid_out <= 1`.
    - If it reaches `LOSS_LIMIT`, do not forward. Go to HUNT with `active <= 0`, `com_cnt <= 0`, `loss_cnt <= 0`.
  - Any other byte: forward it (`data_out <= w`, `valid_out <= 1`) and set `loss_cnt <= 0`.
- `valid_out <= 0` on every edge that does not forward a byte.
- `data_out` changes only on a forward or on reset.
- `com_cnt` holds its saturated value while ACTIVE.

## Timing
- Reset values: `active = 0`, `data_out = 8'h00`, `valid_out = 0`, `com_cnt = 0`, `sr = 0`, `bit_cnt = 0`, `loss_cnt = 0`, state HUNT.
- The first COM completes at edge k, meaning its last bit is sampled at k. Subsequent aligned COM boundaries fall at edges k+8, k+16, and so on.
- With `COM_NEEDED = 4`, `active` is high after edge k+24.
- The fourth COM is never forwarded.
- Forward latency: the last bit of a byte is sampled at edge b; `data_out`/`valid_out` are visible after edge b, i.e. zero added cycles beyond the sampling edge.
- `valid_out` is high for exactly 1 cycle.
- At most one strobe per 8 cycles.
- Loss of sync: `active` falls after the boundary edge of the `LOSS_LIMIT`-th stuck byte. On that edge `valid_out` is 0.
- Re-acquisition after loss starts in HUNT on the next edge. The bits already in `sr` count toward the next match.
- `reset` asserted mid-SYNCING or mid-ACTIVE: all registers take their reset values on that edge. HUNT resumes on the first edge with `reset = 0`.

## Test plan
- Reset: drive `reset = 1` for 2 cycles with random serial input -> all outputs 0 throughout; HUNT entered on the first edge after reset is released.
- Acquisition at an arbitrary offset: 3 filler bits 1,1,0, then 4× 0xBC (1,0,1,1,1,1,0,0) -> `com_cnt` steps 1,2,3,4 at boundaries 8 cycles apart; `active` rises at the 4th boundary; no `valid_out` pulse.
- Broken sync: 0xBC, 0xBC, 0x3C -> `com_cnt` reaches 2, then returns to 0 at the third boundary; `active` stays 0.
- Data forwarding: active link, then bytes 0xFC, 0xBC, 0x12 -> `valid_out` pulses with `data_out = 8'hFC`, and 16 cycles later with `data_out = 8'h12`; no pulse on 0xBC; `data_out` holds 8'hFC in between.
- Stuck-line handling, `LOSS_LIMIT = 4`:
  - Active link, 3× 0x00 then 0x55 -> three valid 0x00 strobes, then 0x55; `active` stays 1.
  - Active link, 4× 0xFF -> three strobes; on the 4th boundary `active` drops, `com_cnt = 0`, no strobe.
- Reset mid-sync: assert `reset` for 1 cycle after the 2nd aligned COM -> `com_cnt = 0`, state HUNT; the next 4 COMs then produce `active = 1` 24 cycles after the first of them completes.
